pes_sdw_sched: RTL and testbench
================================

// Module: pes_sdw_sched
// PURPOSE
//  Shares one serial sequence-detector datapath between N_REQ requesters, using round-robin arbitration.
//  Grants one requester at a time, latches its parallel word and serialises it MSB-first into the detector.
//  Counts pattern matches and returns the count with a one-cycle done pulse to the owning requester.
//  Sits between the host-side requesters and the serial detector.
// PARAMETERS
//  N_REQ   2                      number of requesters (>=2)
//  WORD_W  8                      bits per job word
//  PAT_W   4                      detected pattern length (2..WORD_W)
//  CNT_W   $clog2(WORD_W+1)       match counter width; never saturates
// PORTS
//  clk      in   1              single clock, rising edge
//  reset    in   1              asynchronous, active-low; 0 = reset
//  req      in   N_REQ          per-requester request; hold high until gnt
//  word     in   N_REQ*WORD_W   requester i word at [i*WORD_W +: WORD_W]
//  pattern  in   PAT_W          pattern to detect; sampled on grant cycle
//  gnt      out  N_REQ          one-hot, one-cycle accept pulse
//  busy     out  1              high from cycle after gnt through done cycle
//  din_o    out  1              serial bit presented to detector this cycle
//  y_o      out  1              registered match flag
//  done     out  N_REQ          one-hot, one-cycle completion pulse to job owner
//  count    out  CNT_W          match count; valid while done!=0
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0; FSM=IDLE; RR pointer=0; history, fill and count cleared.
//  - FSM states:
//    - IDLE: if |req, pick the first set req at or after the pointer (cyclic order).
//      Pulse gnt[w]; latch word[w], pattern and owner=w; clear history, fill, count and bit index; pointer<=(w+1)%N_REQ.
//      Go to SHIFT. If req==0, stay in IDLE.
//    - SHIFT: WORD_W cycles, k=0..WORD_W-1, with din_o=latched_word[WORD_W-1-k].
//      At each edge: hist<={hist[PAT_W-2:0],din_o}; m=(fill>=PAT_W-1)&&({hist[PAT_W-2:0],din_o}==pattern_l).
//      Then y_o<=m; count<=count+m; fill<=min(fill+1,PAT_W).
//      After k=WORD_W-1, go to DONE.
//    - DONE: done[owner]=1 for exactly one cycle with final count (includes last-bit match); y_o<=0; go to IDLE.
//  - Job length: grant cycle + WORD_W + 1 done cycle; the next gnt comes at the earliest on the cycle after DONE.
//  - Matches never span jobs: history and fill are cleared on every grant.
//  - A req dropped before its gnt is not serviced. req, word and pattern changes after gnt are ignored.
//  - Simultaneous requests are resolved by the RR pointer only; a requester is never granted twice while another is waiting.
//  - busy=0, din_o=0 and y_o=0 in IDLE; count holds its last value after DONE.
//  - Reset mid-job: the job is discarded and no done is issued; the requester must re-request.
// CONFIGURATION
//  SDW_OVERLAP_EN defined: overlapping detection (fill is not cleared on a match).
//  Not defined: non-overlapping detection (on m=1, fill<=0, so the next match needs PAT_W fresh bits).
// STRUCTURE
//  Package pes_sdw_pkg:
//  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) as a typedef enum
//  - default WORD_W, PAT_W
//  - rr_pick function (req vector and pointer in, one-hot grant out)
//  Sub-module pes_sdw_match: history shift register + fill counter + comparator.
//  - inputs: clk, reset, clr, en, bit_i, pattern
//  - output: m
//  - honours SDW_OVERLAP_EN
//  Top level: FSM, arbiter, word latch, bit index, count.
// TESTING (WORD_W=8, PAT_W=4, N_REQ=2)
//  1. req=2'b01, word0=8'hAA, pattern=4'b1010, overlap build -> gnt=01; y_o high after bits 3,5,7.
//     done=01 at cycle 9 after gnt, count=3. Non-overlap build: count=2.
//  2. req=2'b11 from reset -> gnt=01 first; gnt=10 on the cycle after done=01; both done, in order 0 then 1.
//  3. word0=8'hBB, pattern=4'b1011 -> count=2 in both builds; word0=8'h00 -> done pulse with count=0.
//  4. pattern changed 1011->0000 mid-SHIFT with word0=8'hBB -> count still 2.
//  5. reset=0 at SHIFT k=4 -> all outputs 0 immediately, no done.
//     After release with req=2'b11 -> gnt=01 (pointer reset to 0).
//  6. req1 held continuously, req0 pulsed during req1's job -> grants alternate 1,0,1; no starvation.

Source files
------------

// File: rtl/pes_sdw_pkg.sv
// Shared types and helpers for the pes_sdw_sched serial-detector scheduler.
// Build option: SDW_OVERLAP_EN (see pes_sdw_match) selects overlapping detection.
package pes_sdw_pkg;

    // FSM encoding shared by the scheduler top level
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_N_REQ  = 2;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_PAT_W  = 4;

    // Widest request vector rr_pick can arbitrate; callers zero-extend into it
    localparam int MAX_REQ    = 32;
    localparam int MAX_IDX_W  = 5;

    // Round-robin pick: first set request at or after ptr, walking cyclically
    // over the n_req live requesters. Returns a one-hot grant (all zero when
    // nothing is requesting). ptr must be below n_req.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req_v,
        input int unsigned        ptr,
        input int unsigned        n_req
    );
        logic [MAX_REQ-1:0]   grant_v;
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        int unsigned          sum;
        grant_v = '0;
        found   = 1'b0;
        for (int unsigned i = 32'd0; i < MAX_REQ; i++) begin
            sum = ptr + i;
            if (sum >= n_req) begin
                sum = sum - n_req;
            end else begin
                sum = sum;
            end
            idx = MAX_IDX_W'(sum);
            if ((i < n_req) && !found && req_v[idx]) begin
                grant_v[idx] = 1'b1;
                found        = 1'b1;
            end else begin
                found = found;
            end
        end
        return grant_v;
    endfunction

endpackage

// File: rtl/pes_sdw_match.sv
// Serial pattern matcher: history shift register, fill counter and comparator.
// Build option SDW_OVERLAP_EN: when defined, a match leaves the fill count
// intact so matches may overlap; otherwise a match empties the history window
// and the next match needs PAT_W fresh bits.
module pes_sdw_match
    import pes_sdw_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pattern,
    output logic             m
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  win_s;
    logic              m_s;
    logic [FILL_W-1:0] fill_sat_s;

    // Window = stored history plus the bit arriving this cycle; compare once enough bits seen
    always_comb begin
        win_s = {hist_q, bit_i};
        m_s   = en && (fill_q >= FILL_W'(PAT_W - 1)) && (win_s == pattern);
        if (fill_q >= FILL_W'(PAT_W)) begin
            fill_sat_s = FILL_W'(PAT_W);
        end else begin
            fill_sat_s = fill_q + FILL_W'(1);
        end
    end

    // Next history/fill: cleared on a new job, advanced on each serial bit
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = win_s[PAT_W-2:0];
`ifdef SDW_OVERLAP_EN
            fill_d = fill_sat_s;
`else
            fill_d = m_s ? FILL_W'(0) : fill_sat_s;
`endif
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // History and fill registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign m = m_s;

endmodule

// File: rtl/pes_sdw_sched.sv
// Round-robin scheduler sharing one serial sequence detector among N_REQ
// requesters: grant, latch the word, shift it MSB-first through the matcher,
// then return the match count with a one-cycle done pulse to the owner.
// Build option: SDW_OVERLAP_EN selects overlapping detection in pes_sdw_match.
module pes_sdw_sched
    import pes_sdw_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] word,
    input  logic [PAT_W-1:0]        pattern,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    din_o,
    output logic                    y_o,
    output logic [N_REQ-1:0]        done,
    output logic [CNT_W-1:0]        count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IDX_W = $clog2(WORD_W);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              y_q, y_d;

    logic [MAX_REQ-1:0] req_ext_s;
    logic [N_REQ-1:0]   pick_s;
    logic [PTR_W-1:0]   win_s;
    logic               take_s;
    logic               din_s;
    logic               m_s;

    // Arbiter: round-robin pick from the pointer; a grant only happens while idle and out of reset
    always_comb begin
        req_ext_s             = '0;
        req_ext_s[N_REQ-1:0]  = req;
        pick_s                = N_REQ'(rr_pick(req_ext_s, 32'(ptr_q), 32'(N_REQ)));
        win_s                 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_s = win_s | (pick_s[i] ? PTR_W'(i) : PTR_W'(0));
        end
        take_s = (state_q == ST_IDLE) && reset && (|req);
    end

    // Serial bit: MSB of the shifting word register, only while shifting
    assign din_s = (state_q == ST_SHIFT) && word_q[WORD_W-1];

    pes_sdw_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (take_s),
        .en      (state_q == ST_SHIFT),
        .bit_i   (din_s),
        .pattern (pattern_q),
        .m       (m_s)
    );

    // Next-state and datapath update for the job FSM
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        word_d    = word_q;
        pattern_d = pattern_q;
        idx_d     = idx_q;
        count_d   = count_q;
        y_d       = y_q;
        case (state_q)
            ST_IDLE: begin
                y_d = 1'b0;
                if (take_s) begin
                    state_d   = ST_SHIFT;
                    word_d    = word[win_s*WORD_W +: WORD_W];
                    pattern_d = pattern;
                    owner_d   = win_s;
                    idx_d     = '0;
                    count_d   = '0;
                    if (win_s == PTR_W'(N_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_s + PTR_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                word_d  = {word_q[WORD_W-2:0], 1'b0};
                idx_d   = idx_q + IDX_W'(1);
                y_d     = m_s;
                count_d = count_q + CNT_W'(m_s);
                if (idx_q == IDX_W'(WORD_W - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                y_d     = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                y_d     = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Job state registers; reset discards any job in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            word_q    <= '0;
            pattern_q <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            word_q    <= word_d;
            pattern_q <= pattern_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            y_q       <= y_d;
        end
    end

    // Output decode from registered state; done is one-hot on the job owner
    always_comb begin
        gnt   = take_s ? pick_s : '0;
        busy  = (state_q != ST_IDLE);
        din_o = din_s;
        y_o   = y_q;
        count = count_q;
        done  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            done[i] = (state_q == ST_DONE) && (owner_q == PTR_W'(i));
        end
    end

endmodule

// File: tb/tb_pes_sdw_sched.sv
// Self-checking bench for pes_sdw_sched (N_REQ=2, WORD_W=8, PAT_W=4).
// Expected counts follow the SDW_OVERLAP_EN build option when it is defined.
module tb_pes_sdw_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] word = 16'h0000;
    logic [3:0]  pattern = 4'h0;
    logic [1:0]  gnt;
    logic        busy;
    logic        din_o;
    logic        y_o;
    logic [1:0]  done;
    logic [3:0]  count;

    pes_sdw_sched dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .word    (word),
        .pattern (pattern),
        .gnt     (gnt),
        .busy    (busy),
        .din_o   (din_o),
        .y_o     (y_o),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

`ifdef SDW_OVERLAP_EN
    localparam int          T1_CNT  = 3;
    localparam logic [8:0]  T1_YMSK = 9'h150;
`else
    localparam int          T1_CNT  = 2;
    localparam logic [8:0]  T1_YMSK = 9'h110;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tb_ptr  = 0;

    typedef struct {
        int owner;
        int cnt;
        int due;
    } job_t;
    job_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference detector: MSB-first shift, window compare once PAT_W-1 bits seen
    function automatic int model_count(input logic [7:0] w, input logic [3:0] p);
        logic [3:0] hist;
        logic [3:0] win;
        logic       mt;
        int         fill;
        int         cnt;
        hist = 4'h0;
        fill = 0;
        cnt  = 0;
        for (int k = 7; k >= 0; k--) begin
            win  = {hist[2:0], w[k]};
            mt   = (fill >= 3) && (win == p);
            hist = win;
            if (mt) cnt++;
            fill = (fill >= 4) ? 4 : fill + 1;
`ifndef SDW_OVERLAP_EN
            if (mt) fill = 0;
`endif
        end
        return cnt;
    endfunction

    // Scoreboard monitor: push expected result on grant, pop and compare on done
    always @(negedge clk) begin
        int   w;
        job_t j;
        if (!reset) begin
            sb.delete();
            tb_ptr = 0;
        end else begin
            if (gnt != 2'b00) begin
                w = req[tb_ptr] ? tb_ptr : 1 - tb_ptr;
                chk("gnt_rr", 32'(gnt), (req == 2'b00) ? 32'd0 : (32'd1 << w));
                chk("gnt_not_busy", 32'(busy), 32'd0);
                j.owner = w;
                j.cnt   = model_count(word[w*8 +: 8], pattern);
                j.due   = cyc + 9;
                sb.push_back(j);
                tb_ptr = (w + 1) % 2;
            end
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    j = sb.pop_front();
                    chk("done_owner", 32'(done), 32'd1 << j.owner);
                    chk("done_count", 32'(count), 32'(j.cnt));
                    chk("done_cycle", 32'(cyc), 32'(j.due));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                j = sb.pop_front();
                chk("done_missing", 32'(done), 32'd1 << j.owner);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_gnt_seen"}, 32'(gnt != 2'b00), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (done == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done != 2'b00), 32'd1);
    endtask

    // Single job from requester 0, optional pattern change two cycles into SHIFT
    task automatic run_job0(input string tag, input logic [7:0] w0, input logic [3:0] pat,
                            input bit chg, input int exp_cnt);
        drive_edge();
        req = 2'b01;
        word = {8'h00, w0};
        pattern = pat;
        wait_gnt(tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd1);
        @(posedge clk);
        #1 req = 2'b00;
        if (chg) begin
            repeat (2) @(posedge clk);
            #1 pattern = 4'b0000;
        end
        wait_done(tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    endtask

    initial begin
        logic [8:0] yv;
        logic [8:0] bv;
        logic [7:0] dv;

        // Reset state, with both requesters already asking
        reset = 1'b0;
        req = 2'b11;
        word = {8'hFF, 8'hF0};
        pattern = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_din", 32'(din_o), 32'd0);
        chk("rst_y", 32'(y_o), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Test 2: both requesting from reset -> 0 first, then 1 right after done
        drive_edge();
        reset = 1'b1;
        wait_gnt("t2a");
        chk("t2_gnt0", 32'(gnt), 32'd1);
        @(posedge clk);
        #1 req = 2'b10;
        wait_done("t2a");
        chk("t2_done0", 32'(done), 32'd1);
        @(negedge clk);
        chk("t2_gnt1_next", 32'(gnt), 32'd2);
        @(posedge clk);
        #1 req = 2'b00;
        wait_done("t2b");
        chk("t2_done1", 32'(done), 32'd2);

        // Test 1: 0xAA / 1010, trace serial bits, busy and y_o across the job
        drive_edge();
        req = 2'b01;
        word = {8'h00, 8'hAA};
        pattern = 4'b1010;
        wait_gnt("t1");
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_busy_at_gnt", 32'(busy), 32'd0);
        @(posedge clk);
        #1 req = 2'b00;
        yv = '0;
        bv = '0;
        dv = '0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            yv[j-1] = y_o;
            bv[j-1] = busy;
            if (j <= 8) dv[8-j] = din_o;
            if (j == 9) begin
                chk("t1_done", 32'(done), 32'd1);
                chk("t1_count", 32'(count), 32'(T1_CNT));
            end
        end
        chk("t1_din_seq", 32'(dv), 32'h0000_00AA);
        chk("t1_busy_seq", 32'(bv), 32'h0000_01FF);
        chk("t1_y_seq", 32'(yv), 32'(T1_YMSK));
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_y", 32'(y_o), 32'd0);
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_count_hold", 32'(count), 32'(T1_CNT));

        // Test 3: 0xBB / 1011 gives 2 in either mode; all-zero word gives 0
        run_job0("t3a", 8'hBB, 4'b1011, 1'b0, 2);
        run_job0("t3b", 8'h00, 4'b1011, 1'b0, 0);

        // Test 4: pattern input changes mid-SHIFT are ignored
        run_job0("t4", 8'hBB, 4'b1011, 1'b1, 2);

        // Test 5: reset at SHIFT k=4 kills the job; pointer restarts at 0
        drive_edge();
        req = 2'b01;
        word = {8'h00, 8'hBB};
        pattern = 4'b1011;
        wait_gnt("t5");
        @(posedge clk);
        #1 req = 2'b00;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_din", 32'(din_o), 32'd0);
        chk("t5_rst_y", 32'(y_o), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done), 32'd0);
            if (j == 2) begin
                #1;
                req = 2'b11;
            end
        end
        drive_edge();
        reset = 1'b1;
        wait_gnt("t5r");
        chk("t5_gnt_after_rst", 32'(gnt), 32'd1);
        @(posedge clk);
        #1 req = 2'b10;
        wait_done("t5r0");
        @(negedge clk);
        chk("t5_gnt1_next", 32'(gnt), 32'd2);
        @(posedge clk);
        #1 req = 2'b00;
        wait_done("t5r1");

        // Test 6: req1 held, req0 arrives mid-job -> grants 1, 0, 1
        drive_edge();
        req = 2'b10;
        word = {8'hB0, 8'hBB};
        pattern = 4'b1011;
        wait_gnt("t6a");
        chk("t6_gnt_a", 32'(gnt), 32'd2);
        repeat (3) @(posedge clk);
        #1 req = 2'b11;
        wait_done("t6a");
        chk("t6_done_a", 32'(done), 32'd2);
        @(negedge clk);
        chk("t6_gnt_b", 32'(gnt), 32'd1);
        @(posedge clk);
        #1 req = 2'b10;
        wait_done("t6b");
        chk("t6_done_b", 32'(done), 32'd1);
        @(negedge clk);
        chk("t6_gnt_c", 32'(gnt), 32'd2);
        @(posedge clk);
        #1 req = 2'b00;
        wait_done("t6c");
        chk("t6_done_c", 32'(done), 32'd2);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
